// File: rtl/ex_hazard_scheduler.sv
// Execute-stage hazard controller: operand forwarding, load-use bubble, branch flush, mul/div sequencing.
// Latency: all strobes combinational from state + inputs; sequencer state updates on the next clk edge.
// Backpressure: a multi-cycle op holds F/D/E for MC_LAT cycles; load-use holds F/D and bubbles E.
module ex_hazard_scheduler #(
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs1_D,
    input  logic [4:0] Rs2_D,
    input  logic [4:0] Rs1_E,
    input  logic [4:0] Rs2_E,
    input  logic [4:0] RD_E,
    input  logic       MemReadE,
    input  logic [4:0] RD_M,
    input  logic       RegWriteM,
    input  logic [4:0] RD_W,
    input  logic       RegWriteW,
    input  logic       PCSrcE,
    input  logic       MultiCycleE,
    output logic [1:0] ForwardA_E,
    output logic [1:0] ForwardB_E,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       MCStart,
    output logic       MCBusy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MC_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit               SINGLE   = (MC_LAT == 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mc_start, mc_stall, load_use;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        // Memory stage holds the younger value, so it wins over writeback; x0 is never forwarded.
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
            return 2'b10;
        else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign mc_start = (state_q == IDLE) && MultiCycleE;
    assign mc_stall = mc_start || (state_q == BUSY);
    assign load_use = MemReadE && (RD_E != 5'd0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (MultiCycleE) begin
                    if (SINGLE) begin
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE)
                    state_d = DONE;
            end
            // Result is ready; the same instruction is still in E, so no restart here.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        ForwardA_E = 2'b00;
        ForwardB_E = 2'b00;
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        MCStart    = 1'b0;
        MCBusy     = 1'b0;
        if (rst) begin
            ForwardA_E = fwd_sel(Rs1_E, RD_M, RegWriteM, RD_W, RegWriteW);
            ForwardB_E = fwd_sel(Rs2_E, RD_M, RegWriteM, RD_W, RegWriteW);
            MCStart    = mc_start;
            MCBusy     = (state_q == BUSY);
            // A taken branch coinciding with an MC stall is deferred to the DONE cycle.
            if (mc_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (load_use) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ex_hazard_scheduler.sv
// Bench for ex_hazard_scheduler: directed vector table, multi-cycle sequences, random vs. reference model.
module tb_ex_hazard_scheduler;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
        logic       memrd;
        logic [4:0] rdm;
        logic       rwm;
        logic [4:0] rdw;
        logic       rww;
        logic       pcsrc;
        logic       mce;
    } in_t;

    typedef struct packed {
        logic [1:0] fa, fb;
        logic       sf, sd, se, fd, fe, mcs, mcb;
    } out_t;

    typedef struct {
        string name;
        in_t   in;
        out_t  exp;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W;
    logic       MemReadE, RegWriteM, RegWriteW, PCSrcE, MultiCycleE;

    logic [1:0] fa [2];
    logic [1:0] fb [2];
    logic       sf [2], sd [2], se [2], fd [2], fe [2], mcs [2], mcb [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: stall cycles still owed after the start cycle, and a result-ready cycle pending.
    int busy_left [2];
    bit done_pend [2];
    int lat [2];

    ex_hazard_scheduler #(.MC_LAT(4), .CNT_W(3)) dut4 (
        .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
        .RD_E(RD_E), .MemReadE(MemReadE), .RD_M(RD_M), .RegWriteM(RegWriteM), .RD_W(RD_W),
        .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .MultiCycleE(MultiCycleE),
        .ForwardA_E(fa[0]), .ForwardB_E(fb[0]), .StallF(sf[0]), .StallD(sd[0]), .StallE(se[0]),
        .FlushD(fd[0]), .FlushE(fe[0]), .MCStart(mcs[0]), .MCBusy(mcb[0])
    );

    ex_hazard_scheduler #(.MC_LAT(1), .CNT_W(3)) dut1 (
        .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
        .RD_E(RD_E), .MemReadE(MemReadE), .RD_M(RD_M), .RegWriteM(RegWriteM), .RD_W(RD_W),
        .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .MultiCycleE(MultiCycleE),
        .ForwardA_E(fa[1]), .ForwardB_E(fb[1]), .StallF(sf[1]), .StallD(sd[1]), .StallE(se[1]),
        .FlushD(fd[1]), .FlushE(fe[1]), .MCStart(mcs[1]), .MCBusy(mcb[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic out_t mk_out(input logic [1:0] a, input logic [1:0] b, input logic f_sf,
                                    input logic f_sd, input logic f_se, input logic f_fd,
                                    input logic f_fe, input logic f_mcs, input logic f_mcb);
        out_t o;
        o.fa = a; o.fb = b; o.sf = f_sf; o.sd = f_sd; o.se = f_se;
        o.fd = f_fd; o.fe = f_fe; o.mcs = f_mcs; o.mcb = f_mcb;
        return o;
    endfunction

    function automatic out_t act_out(input int k);
        return mk_out(fa[k], fb[k], sf[k], sd[k], se[k], fd[k], fe[k], mcs[k], mcb[k]);
    endfunction

    function automatic in_t idle_in();
        in_t v = '0;
        v.rst = 1'b1;
        return v;
    endfunction

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (RegWriteM && RD_M != 0 && RD_M == rs) return 2'b10;
        if (RegWriteW && RD_W != 0 && RD_W == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic out_t model_out(input int k);
        out_t e = '0;
        bit start, stall, lu;
        if (!rst) return e;
        start = (busy_left[k] == 0) && !done_pend[k] && MultiCycleE;
        stall = start || (busy_left[k] > 0);
        lu    = MemReadE && RD_E != 0 && (RD_E == Rs1_D || RD_E == Rs2_D);
        e.fa  = fwd_ref(Rs1_E);
        e.fb  = fwd_ref(Rs2_E);
        e.mcs = start;
        e.mcb = (busy_left[k] > 0);
        if (stall) begin
            e.sf = 1; e.sd = 1; e.se = 1;
        end else if (PCSrcE) begin
            e.fd = 1; e.fe = 1;
        end else if (lu) begin
            e.sf = 1; e.sd = 1; e.fe = 1;
        end
        return e;
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                busy_left[k] = 0;
                done_pend[k] = 0;
            end else if (done_pend[k]) begin
                done_pend[k] = 0;
            end else if (busy_left[k] > 0) begin
                busy_left[k]--;
                if (busy_left[k] == 0) done_pend[k] = 1;
            end else if (MultiCycleE) begin
                if (lat[k] == 1) done_pend[k] = 1;
                else             busy_left[k] = lat[k] - 1;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string name);
        for (int k = 0; k < 2; k++) begin
            out_t a = act_out(k);
            out_t e = model_out(k);
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s dut%0d @%0t: got %h, expected %h", name, k, $time, a, e);
            end
        end
    endtask

    task automatic drive(input in_t v, input string name);
        @(negedge clk);
        rst = v.rst; Rs1_D = v.rs1d; Rs2_D = v.rs2d; Rs1_E = v.rs1e; Rs2_E = v.rs2e;
        RD_E = v.rde; MemReadE = v.memrd; RD_M = v.rdm; RegWriteM = v.rwm;
        RD_W = v.rdw; RegWriteW = v.rww; PCSrcE = v.pcsrc; MultiCycleE = v.mce;
        #1;
        check_model(name);
        model_step();
    endtask

    function automatic in_t rand_in();
        in_t v;
        v.rst   = ($urandom_range(0, 49) != 0);
        v.rs1d  = 5'($urandom_range(0, 7));
        v.rs2d  = 5'($urandom_range(0, 7));
        v.rs1e  = 5'($urandom_range(0, 7));
        v.rs2e  = 5'($urandom_range(0, 7));
        v.rde   = 5'($urandom_range(0, 7));
        v.memrd = ($urandom_range(0, 2) == 0);
        v.rdm   = 5'($urandom_range(0, 7));
        v.rwm   = $urandom_range(0, 1) != 0;
        v.rdw   = 5'($urandom_range(0, 7));
        v.rww   = $urandom_range(0, 1) != 0;
        v.pcsrc = ($urandom_range(0, 6) == 0);
        v.mce   = ($urandom_range(0, 4) == 0);
        return v;
    endfunction

    vec_t tbl [11];

    initial begin
        in_t v;
        bit  e4_mcs [6] = '{1, 0, 0, 0, 0, 1};
        bit  e4_se  [6] = '{1, 1, 1, 1, 0, 1};
        bit  e4_mcb [6] = '{0, 1, 1, 1, 0, 0};
        bit  e1_mcs [6] = '{1, 0, 1, 0, 1, 0};

        lat[0] = 4; lat[1] = 1;
        busy_left[0] = 0; busy_left[1] = 0; done_pend[0] = 0; done_pend[1] = 0;

        for (int i = 0; i < 11; i++) tbl[i].in = idle_in();
        tbl[0].name = "fwdA_M_over_W";
        tbl[0].in.rwm = 1; tbl[0].in.rdm = 5; tbl[0].in.rww = 1; tbl[0].in.rdw = 5; tbl[0].in.rs1e = 5;
        tbl[0].exp = mk_out(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        tbl[1].name = "fwdA_W_rdm0";
        tbl[1].in = tbl[0].in; tbl[1].in.rdm = 0;
        tbl[1].exp = mk_out(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        tbl[2].name = "fwdA_none";
        tbl[2].in = tbl[0].in; tbl[2].in.rwm = 0; tbl[2].in.rww = 0;
        tbl[2].exp = mk_out(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        tbl[3].name = "fwdB_M";
        tbl[3].in.rs2e = 9; tbl[3].in.rdm = 9; tbl[3].in.rwm = 1;
        tbl[3].exp = mk_out(2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 0);
        tbl[4].name = "fwd_x0";
        tbl[4].in.rwm = 1; tbl[4].in.rww = 1;
        tbl[4].exp = mk_out(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        tbl[5].name = "fwd_mix";
        tbl[5].in.rs1e = 3; tbl[5].in.rs2e = 4; tbl[5].in.rdm = 4; tbl[5].in.rwm = 1;
        tbl[5].in.rdw = 3; tbl[5].in.rww = 1;
        tbl[5].exp = mk_out(2'b01, 2'b10, 0, 0, 0, 0, 0, 0, 0);
        tbl[6].name = "load_use";
        tbl[6].in.memrd = 1; tbl[6].in.rde = 7; tbl[6].in.rs2d = 7;
        tbl[6].exp = mk_out(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0);
        tbl[7].name = "load_use_released";
        tbl[7].in.rde = 7; tbl[7].in.rs2d = 7;
        tbl[7].exp = mk_out(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        tbl[8].name = "load_use_branch";
        tbl[8].in = tbl[6].in; tbl[8].in.pcsrc = 1;
        tbl[8].exp = mk_out(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0);
        tbl[9].name = "load_use_x0";
        tbl[9].in.memrd = 1;
        tbl[9].exp = mk_out(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        tbl[10].name = "branch_only";
        tbl[10].in.pcsrc = 1; tbl[10].in.rs1d = 2;
        tbl[10].exp = mk_out(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0);

        rst = 0; Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0; RD_E = 0; MemReadE = 0;
        RD_M = 0; RegWriteM = 0; RD_W = 0; RegWriteW = 0; PCSrcE = 0; MultiCycleE = 0;

        // Reset with active-looking inputs: every output must stay low.
        v = tbl[0].in; v.rst = 0; v.mce = 1; v.pcsrc = 1;
        for (int i = 0; i < 2; i++) begin
            drive(v, "reset");
            chk("reset_outputs_dut4", int'(act_out(0)), 0);
            chk("reset_outputs_dut1", int'(act_out(1)), 0);
        end

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].in, tbl[i].name);
            for (int k = 0; k < 2; k++)
                chk($sformatf("%s_dut%0d", tbl[i].name, k), int'(act_out(k)), int'(tbl[i].exp));
        end

        // MultiCycleE held: MC_LAT=4 stalls 4 cycles, one DONE gap, then restarts; MC_LAT=1 alternates.
        v = idle_in(); v.mce = 1;
        for (int c = 0; c < 6; c++) begin
            drive(v, "mc_held");
            chk($sformatf("mc4_start_c%0d", c), int'(mcs[0]), int'(e4_mcs[c]));
            chk($sformatf("mc4_stallE_c%0d", c), int'(se[0]), int'(e4_se[c]));
            chk($sformatf("mc4_busy_c%0d", c), int'(mcb[0]), int'(e4_mcb[c]));
            chk($sformatf("mc1_start_c%0d", c), int'(mcs[1]), int'(e1_mcs[c]));
            chk($sformatf("mc1_stallE_c%0d", c), int'(se[1]), int'(e1_mcs[c]));
        end

        // Branch arriving with an MC start is deferred; it takes effect in the DONE cycle.
        v = idle_in(); v.rst = 0;
        drive(v, "realign");
        v = idle_in(); v.mce = 1; v.pcsrc = 1;
        for (int c = 0; c < 5; c++) drive(v, "mc_vs_branch");
        chk("mc4_done_branch_flushD", int'(fd[0]), 1);
        chk("mc4_done_branch_stallF", int'(sf[0]), 0);

        // Reset during the second BUSY cycle, then only a fresh request may start the unit.
        v = idle_in(); v.rst = 0;
        drive(v, "realign2");
        v = idle_in(); v.mce = 1;
        drive(v, "mc_rst_start");
        drive(v, "mc_rst_busy1");
        v.rst = 0;
        drive(v, "mc_rst_busy2");
        chk("rst_mid_busy_outputs", int'(act_out(0)), 0);
        v = idle_in();
        drive(v, "mc_rst_after");
        chk("after_rst_outputs", int'(act_out(0)), 0);
        drive(v, "mc_rst_idle");
        chk("after_rst_no_start", int'(mcs[0]), 0);
        v.mce = 1;
        drive(v, "mc_rst_fresh");
        chk("fresh_start", int'(mcs[0]), 1);
        chk("fresh_stallE", int'(se[0]), 1);

        for (int i = 0; i < 3000; i++) drive(rand_in(), "random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
